trdb_pkt_priority: RTL and testbench
====================================

Name: trdb_pkt_priority

Overview:
- Packet-priority decision block of the RISC-V E-Trace instruction encoder (trdb).
- Takes per-instruction qualification and event flags for three pipeline stages: last (lc_), this/current (tc_) and next (nc_).
- Decides whether a te_inst packet is emitted for the current instruction, and which format/subformat.
- Drives the mux selects and the resync-timer reset used by the packet emitter downstream.

Parameters:
- none

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  current-stage instruction info valid
- lc_exception_i  in  1  last instruction took exception
- lc_updiscon_i  in  1  last instruction was uninferable discontinuity
- tc_qualified_i  in  1  current instruction qualified for trace
- tc_exception_i  in  1  current instruction takes exception
- tc_retired_i  in  1  current instruction retired
- tc_first_qualified_i  in  1  first qualified after unqualified
- tc_privchange_i  in  1  privilege change
- tc_context_change_i  in  1  context change
- tc_gt_max_resync_i  in  1  resync counter > max
- tc_et_max_resync_i  in  1  resync counter == max
- tc_branch_map_empty_i  in  1  branch map holds no branches
- tc_branch_map_full_i  in  1  branch map full (31)
- tc_enc_enabled_i  in  1  encoder just enabled
- tc_enc_disabled_i  in  1  encoder just disabled
- tc_opmode_change_i  in  1  operating mode changed
- lc_final_qualified_i  in  1  last instruction was final qualified
- nc_exception_i, nc_privchange_i, nc_context_change_i  in  1 each  next-instruction events
- nc_branch_map_empty_i  in  1  branch map empty after next
- nc_qualified_i, nc_retired_i  in  1 each  next-instruction status
- valid_o  out  1  packet required
- packet_format_o  out  2  0 opt-ext, 1 diff-delta, 2 addr-only, 3 sync
- packet_f_sync_subformat_o  out  2  0 start, 1 trap, 2 context, 3 support
- thaddr_o  out  1  trap-handler address flag
- cause_mux_o  out  1  0 = last-stage cause, 1 = current-stage cause
- tval_mux_o  out  1  same selection for tval
- resync_timer_rst_o  out  1  reset resync counter
- qual_status_o  out  2  0 no_change, 1 ended_rep, 2 trace_lost, 3 ended_ntr

Behaviour:
- Outputs are combinational from the inputs and the internal state: zero latency, valid in the same cycle.
- Default output (no packet, valid_i=0, or rst_ni=0): all outputs 0.
- F12 selects the data format: 1 if tc_branch_map_empty_i=0, else 2.
- Internal register started_q: synchronous reset to 0.
  - Set when any packet is emitted with tc_qualified_i=1.
  - Cleared on a support packet carrying qual_status 1 or 3.
- Priority when valid_i=1 and tc_qualified_i=1 (first match wins):
  1. lc_exception_i: format 3, subformat 1, thaddr=1, cause/tval mux=0, resync_rst=1.
  2. tc_exception_i & !tc_retired_i: format 3, subformat 1, thaddr=0, cause/tval mux=1, resync_rst=1.
  3. tc_first_qualified_i | tc_privchange_i | tc_gt_max_resync_i | !started_q: format 3, subformat 0, resync_rst=1.
  4. tc_context_change_i: format 3, subformat 2, resync_rst=1.
  5. lc_updiscon_i: format F12.
  6. tc_et_max_resync_i & !tc_branch_map_empty_i: format 1.
  7. tc_branch_map_full_i: format 1.
  8. Any of nc_exception_i, nc_privchange_i, nc_context_change_i, !nc_qualified_i, lc_final_qualified_i: format F12.
  9. Otherwise: no packet.
- Cases 5–8 drive thaddr_o and both mux selects to 0.
- Priority when valid_i=1 and tc_qualified_i=0:
  - tc_enc_disabled_i: format 3, subformat 3; qual_status = 1 if lc_final_qualified_i, else 3.
  - Else tc_enc_enabled_i or tc_opmode_change_i: format 3, subformat 3, qual_status 0.
  - Else no packet.
- nc_branch_map_empty_i and nc_retired_i are accepted but affect no decision.
- qual_status 2 is never generated.
- Reset asserted mid-trace: started_q clears, so the next qualified instruction emits a start packet.

Optional Feature:
- TRDB_PRIORITY_OUT_REG_EN defined: all outputs registered on clk_i, 1-cycle latency, synchronous reset to 0.
- Undefined: outputs combinational as above (default build).

Test Plan:
- rst_ni=0, all inputs 1 -> all outputs 0; then qualified instruction with tc_first_qualified=0 -> format 3, subformat 0, resync_rst=1.
- valid=1, qualified, lc_exception=1 -> valid=1, format 3, subformat 1, thaddr=1, cause/tval mux=0.
- valid=1, qualified, started, tc_exception=1, tc_retired=0 -> format 3, subformat 1, thaddr=0, muxes=1.
- valid=1, qualified, started, lc_updiscon=1: branch_map_empty=1 -> format 2; branch_map_empty=0 -> format 1.
- Qualified, started, only branch_map_full=1 -> format 1; with no flags set and nc_qualified=1 -> valid=0.
- Unqualified, enc_disabled=1: lc_final_qualified=1 -> format 3, subformat 3, qual_status 1; lc_final_qualified=0 -> qual_status 3, and the next qualified instruction gives a start packet.

Source files
------------

// File: rtl/trdb_pkt_priority.sv
// Packet-priority decision for the trdb E-Trace encoder: picks te_inst format/subformat and emitter controls.
// Optional macro TRDB_PRIORITY_OUT_REG_EN registers every output (1-cycle latency); default is combinational.
module trdb_pkt_priority (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic       lc_exception_i,
  input  logic       lc_updiscon_i,
  input  logic       tc_qualified_i,
  input  logic       tc_exception_i,
  input  logic       tc_retired_i,
  input  logic       tc_first_qualified_i,
  input  logic       tc_privchange_i,
  input  logic       tc_context_change_i,
  input  logic       tc_gt_max_resync_i,
  input  logic       tc_et_max_resync_i,
  input  logic       tc_branch_map_empty_i,
  input  logic       tc_branch_map_full_i,
  input  logic       tc_enc_enabled_i,
  input  logic       tc_enc_disabled_i,
  input  logic       tc_opmode_change_i,
  input  logic       lc_final_qualified_i,
  input  logic       nc_exception_i,
  input  logic       nc_privchange_i,
  input  logic       nc_context_change_i,
  input  logic       nc_branch_map_empty_i,
  input  logic       nc_qualified_i,
  input  logic       nc_retired_i,
  output logic       valid_o,
  output logic [1:0] packet_format_o,
  output logic [1:0] packet_f_sync_subformat_o,
  output logic       thaddr_o,
  output logic       cause_mux_o,
  output logic       tval_mux_o,
  output logic       resync_timer_rst_o,
  output logic [1:0] qual_status_o
);

  typedef enum logic [1:0] {
    FMT_OPT_EXT = 2'd0,
    FMT_DIFF    = 2'd1,
    FMT_ADDR    = 2'd2,
    FMT_SYNC    = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } subfmt_e;

  typedef enum logic [1:0] {
    QS_NO_CHANGE  = 2'd0,
    QS_ENDED_REP  = 2'd1,
    QS_TRACE_LOST = 2'd2,
    QS_ENDED_NTR  = 2'd3
  } qual_e;

  typedef struct packed {
    logic    valid;
    fmt_e    fmt;
    subfmt_e subfmt;
    logic    thaddr;
    logic    cause_mux;
    logic    tval_mux;
    logic    resync_rst;
    qual_e   qual;
  } decision_t;

  decision_t dec;
  decision_t out;
  fmt_e      data_fmt;
  logic      started_q;
  logic      need_start;
  logic      nc_flush;
  logic      clears_started;
  logic      unused_nc;

  // These next-stage flags are part of the encoder interface but do not influence the decision.
  assign unused_nc = nc_branch_map_empty_i ^ nc_retired_i;

  // Differential format only pays off when there are branches to report.
  assign data_fmt   = tc_branch_map_empty_i ? FMT_ADDR : FMT_DIFF;
  assign need_start = tc_first_qualified_i | tc_privchange_i | tc_gt_max_resync_i | ~started_q;
  assign nc_flush   = nc_exception_i | nc_privchange_i | nc_context_change_i |
                      ~nc_qualified_i | lc_final_qualified_i;

  always_comb begin
    // NOTE: assign the whole decision a default first so no path leaves a field unassigned (no latch).
    dec = '0;
    if (rst_ni && valid_i) begin
      if (tc_qualified_i) begin
        if (lc_exception_i) begin
          dec.valid      = 1'b1;
          dec.fmt        = FMT_SYNC;
          dec.subfmt     = SF_TRAP;
          dec.thaddr     = 1'b1;
          dec.resync_rst = 1'b1;
        end else if (tc_exception_i && !tc_retired_i) begin
          // Trap on an instruction that never retired: cause/tval belong to the current stage.
          dec.valid      = 1'b1;
          dec.fmt        = FMT_SYNC;
          dec.subfmt     = SF_TRAP;
          dec.cause_mux  = 1'b1;
          dec.tval_mux   = 1'b1;
          dec.resync_rst = 1'b1;
        end else if (need_start) begin
          dec.valid      = 1'b1;
          dec.fmt        = FMT_SYNC;
          dec.subfmt     = SF_START;
          dec.resync_rst = 1'b1;
        end else if (tc_context_change_i) begin
          dec.valid      = 1'b1;
          dec.fmt        = FMT_SYNC;
          dec.subfmt     = SF_CONTEXT;
          dec.resync_rst = 1'b1;
        end else if (lc_updiscon_i) begin
          dec.valid = 1'b1;
          dec.fmt   = data_fmt;
        end else if (tc_et_max_resync_i && !tc_branch_map_empty_i) begin
          dec.valid = 1'b1;
          dec.fmt   = FMT_DIFF;
        end else if (tc_branch_map_full_i) begin
          dec.valid = 1'b1;
          dec.fmt   = FMT_DIFF;
        end else if (nc_flush) begin
          dec.valid = 1'b1;
          dec.fmt   = data_fmt;
        end
      end else begin
        if (tc_enc_disabled_i) begin
          dec.valid  = 1'b1;
          dec.fmt    = FMT_SYNC;
          dec.subfmt = SF_SUPPORT;
          dec.qual   = lc_final_qualified_i ? QS_ENDED_REP : QS_ENDED_NTR;
        end else if (tc_enc_enabled_i || tc_opmode_change_i) begin
          dec.valid  = 1'b1;
          dec.fmt    = FMT_SYNC;
          dec.subfmt = SF_SUPPORT;
          dec.qual   = QS_NO_CHANGE;
        end
      end
    end
  end

  // A support packet that ends tracing forces a fresh start packet on the next qualified instruction.
  assign clears_started = dec.valid && (dec.fmt == FMT_SYNC) && (dec.subfmt == SF_SUPPORT) &&
                          ((dec.qual == QS_ENDED_REP) || (dec.qual == QS_ENDED_NTR));

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      started_q <= 1'b0;
    end else if (clears_started) begin
      started_q <= 1'b0;
    end else if (dec.valid && tc_qualified_i) begin
      started_q <= 1'b1;
    end
  end

`ifdef TRDB_PRIORITY_OUT_REG_EN
  decision_t out_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      out_q <= dec;
    end
  end

  assign out = out_q;
`else
  assign out = dec;
`endif

  assign valid_o                   = out.valid;
  assign packet_format_o           = out.fmt;
  assign packet_f_sync_subformat_o = out.subfmt;
  assign thaddr_o                  = out.thaddr;
  assign cause_mux_o               = out.cause_mux;
  assign tval_mux_o                = out.tval_mux;
  assign resync_timer_rst_o        = out.resync_rst;
  assign qual_status_o             = out.qual;

endmodule

// File: tb/tb_trdb_pkt_priority.sv
// Directed bench for trdb_pkt_priority: expected packets are queued as stimulus is driven and
// compared against the DUT outputs mid-cycle.
module tb_trdb_pkt_priority;

  typedef struct packed {
    logic       valid;
    logic [1:0] fmt;
    logic [1:0] subfmt;
    logic       thaddr;
    logic       cause_mux;
    logic       tval_mux;
    logic       resync_rst;
    logic [1:0] qual;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic valid_i, lc_exception_i, lc_updiscon_i, tc_qualified_i, tc_exception_i, tc_retired_i;
  logic tc_first_qualified_i, tc_privchange_i, tc_context_change_i, tc_gt_max_resync_i;
  logic tc_et_max_resync_i, tc_branch_map_empty_i, tc_branch_map_full_i, tc_enc_enabled_i;
  logic tc_enc_disabled_i, tc_opmode_change_i, lc_final_qualified_i;
  logic nc_exception_i, nc_privchange_i, nc_context_change_i, nc_branch_map_empty_i;
  logic nc_qualified_i, nc_retired_i;
  logic       valid_o, thaddr_o, cause_mux_o, tval_mux_o, resync_timer_rst_o;
  logic [1:0] packet_format_o, packet_f_sync_subformat_o, qual_status_o;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk_i = ~clk_i;

  trdb_pkt_priority dut (
    .clk_i                     (clk_i),
    .rst_ni                    (rst_ni),
    .valid_i                   (valid_i),
    .lc_exception_i            (lc_exception_i),
    .lc_updiscon_i             (lc_updiscon_i),
    .tc_qualified_i            (tc_qualified_i),
    .tc_exception_i            (tc_exception_i),
    .tc_retired_i              (tc_retired_i),
    .tc_first_qualified_i      (tc_first_qualified_i),
    .tc_privchange_i           (tc_privchange_i),
    .tc_context_change_i       (tc_context_change_i),
    .tc_gt_max_resync_i        (tc_gt_max_resync_i),
    .tc_et_max_resync_i        (tc_et_max_resync_i),
    .tc_branch_map_empty_i     (tc_branch_map_empty_i),
    .tc_branch_map_full_i      (tc_branch_map_full_i),
    .tc_enc_enabled_i          (tc_enc_enabled_i),
    .tc_enc_disabled_i         (tc_enc_disabled_i),
    .tc_opmode_change_i        (tc_opmode_change_i),
    .lc_final_qualified_i      (lc_final_qualified_i),
    .nc_exception_i            (nc_exception_i),
    .nc_privchange_i           (nc_privchange_i),
    .nc_context_change_i       (nc_context_change_i),
    .nc_branch_map_empty_i     (nc_branch_map_empty_i),
    .nc_qualified_i            (nc_qualified_i),
    .nc_retired_i              (nc_retired_i),
    .valid_o                   (valid_o),
    .packet_format_o           (packet_format_o),
    .packet_f_sync_subformat_o (packet_f_sync_subformat_o),
    .thaddr_o                  (thaddr_o),
    .cause_mux_o               (cause_mux_o),
    .tval_mux_o                (tval_mux_o),
    .resync_timer_rst_o        (resync_timer_rst_o),
    .qual_status_o             (qual_status_o)
  );

  function automatic exp_t mk(input logic v, input logic [1:0] f, input logic [1:0] s,
                              input logic th, input logic cm, input logic tm,
                              input logic rr, input logic [1:0] q);
    mk = '{valid: v, fmt: f, subfmt: s, thaddr: th, cause_mux: cm, tval_mux: tm,
           resync_rst: rr, qual: q};
  endfunction

  task automatic set_all(input logic b);
    valid_i = b; lc_exception_i = b; lc_updiscon_i = b; tc_qualified_i = b;
    tc_exception_i = b; tc_retired_i = b; tc_first_qualified_i = b; tc_privchange_i = b;
    tc_context_change_i = b; tc_gt_max_resync_i = b; tc_et_max_resync_i = b;
    tc_branch_map_empty_i = b; tc_branch_map_full_i = b; tc_enc_enabled_i = b;
    tc_enc_disabled_i = b; tc_opmode_change_i = b; lc_final_qualified_i = b;
    nc_exception_i = b; nc_privchange_i = b; nc_context_change_i = b;
    nc_branch_map_empty_i = b; nc_qualified_i = b; nc_retired_i = b;
  endtask

  // Quiet qualified instruction: only valid, qualified and a qualified next instruction.
  task automatic quiet_qualified();
    set_all(1'b0);
    valid_i = 1'b1; tc_qualified_i = 1'b1; nc_qualified_i = 1'b1;
  endtask

  task automatic quiet_unqualified();
    set_all(1'b0);
    valid_i = 1'b1; nc_qualified_i = 1'b1;
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic step(input string tag, input exp_t e);
    exp_t obs, want;
    exp_q.push_back(e);
    #2;
    obs = '{valid: valid_o, fmt: packet_format_o, subfmt: packet_f_sync_subformat_o,
            thaddr: thaddr_o, cause_mux: cause_mux_o, tval_mux: tval_mux_o,
            resync_rst: resync_timer_rst_o, qual: qual_status_o};
    want = exp_q.pop_front();
    n_checks++;
    assert (obs === want) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b (v fmt sub th cm tm rr qs)", tag, obs, want);
    end
    @(negedge clk_i);
  endtask

  localparam exp_t NONE = '0;

  initial begin
    rst_ni = 1'b0;
    set_all(1'b1);
    @(negedge clk_i);
    step("reset_all_ones", NONE);

    rst_ni = 1'b1;
    quiet_qualified();
    step("first_after_reset_start", mk(1, 3, 0, 0, 0, 0, 1, 0));

    quiet_qualified(); lc_exception_i = 1'b1;
    step("lc_exception_trap", mk(1, 3, 1, 1, 0, 0, 1, 0));

    quiet_qualified(); tc_exception_i = 1'b1;
    step("tc_exception_trap", mk(1, 3, 1, 0, 1, 1, 1, 0));

    quiet_qualified(); tc_exception_i = 1'b1; tc_retired_i = 1'b1;
    step("tc_exception_retired_none", NONE);

    quiet_qualified(); tc_privchange_i = 1'b1; tc_context_change_i = 1'b1;
    step("privchange_over_context", mk(1, 3, 0, 0, 0, 0, 1, 0));

    quiet_qualified(); tc_context_change_i = 1'b1;
    step("context_change", mk(1, 3, 2, 0, 0, 0, 1, 0));

    quiet_qualified(); lc_updiscon_i = 1'b1; tc_branch_map_empty_i = 1'b1;
    step("updiscon_map_empty_fmt2", mk(1, 2, 0, 0, 0, 0, 0, 0));

    quiet_qualified(); lc_updiscon_i = 1'b1;
    step("updiscon_map_nonempty_fmt1", mk(1, 1, 0, 0, 0, 0, 0, 0));

    quiet_qualified(); tc_et_max_resync_i = 1'b1;
    step("et_max_resync_fmt1", mk(1, 1, 0, 0, 0, 0, 0, 0));

    quiet_qualified(); tc_et_max_resync_i = 1'b1; tc_branch_map_empty_i = 1'b1;
    step("et_max_resync_empty_none", NONE);

    quiet_qualified(); tc_branch_map_full_i = 1'b1;
    step("branch_map_full_fmt1", mk(1, 1, 0, 0, 0, 0, 0, 0));

    quiet_qualified(); nc_branch_map_empty_i = 1'b1; nc_retired_i = 1'b1;
    step("quiet_no_packet", NONE);

    quiet_qualified(); nc_qualified_i = 1'b0; tc_branch_map_empty_i = 1'b1;
    step("nc_unqualified_fmt2", mk(1, 2, 0, 0, 0, 0, 0, 0));

    quiet_qualified(); nc_exception_i = 1'b1;
    step("nc_exception_fmt1", mk(1, 1, 0, 0, 0, 0, 0, 0));

    quiet_qualified(); lc_final_qualified_i = 1'b1; tc_branch_map_empty_i = 1'b1;
    step("lc_final_qualified_fmt2", mk(1, 2, 0, 0, 0, 0, 0, 0));

    set_all(1'b1); valid_i = 1'b0;
    step("valid_low_none", NONE);

    quiet_unqualified(); tc_enc_disabled_i = 1'b1; lc_final_qualified_i = 1'b1;
    step("disabled_ended_rep", mk(1, 3, 3, 0, 0, 0, 0, 1));

    quiet_qualified();
    step("start_after_ended_rep", mk(1, 3, 0, 0, 0, 0, 1, 0));

    quiet_unqualified(); tc_enc_disabled_i = 1'b1; tc_enc_enabled_i = 1'b1;
    step("disabled_ended_ntr", mk(1, 3, 3, 0, 0, 0, 0, 3));

    quiet_qualified(); tc_context_change_i = 1'b1;
    step("start_after_ended_ntr", mk(1, 3, 0, 0, 0, 0, 1, 0));

    quiet_unqualified(); tc_enc_enabled_i = 1'b1;
    step("enabled_support", mk(1, 3, 3, 0, 0, 0, 0, 0));

    quiet_qualified();
    step("enabled_keeps_started", NONE);

    quiet_unqualified(); tc_opmode_change_i = 1'b1;
    step("opmode_change_support", mk(1, 3, 3, 0, 0, 0, 0, 0));

    quiet_unqualified(); lc_exception_i = 1'b1; tc_context_change_i = 1'b1;
    step("unqualified_quiet_none", NONE);

    quiet_qualified(); tc_gt_max_resync_i = 1'b1; lc_updiscon_i = 1'b1;
    step("gt_max_resync_start", mk(1, 3, 0, 0, 0, 0, 1, 0));

    rst_ni = 1'b0;
    quiet_qualified(); lc_updiscon_i = 1'b1;
    step("mid_trace_reset_zero", NONE);

    rst_ni = 1'b1;
    quiet_qualified(); lc_updiscon_i = 1'b1;
    step("start_after_mid_reset", mk(1, 3, 0, 0, 0, 0, 1, 0));

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
